t_toggle_counter: RTL and testbench
===================================

# t_toggle_counter

Synchronous WIDTH-bit up/down counter built from T-type toggle stages. It generates the per-bit toggle-enable vector and feeds it into a bank of toggle flip-flops with complementary outputs. It sits directly downstream of the single-bit toggle flip-flop in the sequential-logic library and is the first multi-bit consumer of that stage. It is used as the generic event counter, divider and timebase in later designs.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥2)
- MODULUS, 10, wrap modulus; used only when TCNT_MODULO_EN is defined (2 ≤ MODULUS ≤ 2^WIDTH)

Ports:
- clk  in  1  single clock, all state updates on posedge
- clr  in  1  reset, asynchronous, active-high
- load  in  1  synchronous parallel load of d
- d  in  WIDTH  load value
- en  in  1  count enable
- up  in  1  direction: 1 = count up, 0 = count down
- q  out  WIDTH  count value, registered
- qb  out  WIDTH  bitwise complement of q, registered in parallel with q
- tc  out  1  terminal count, combinational from q and up
- ovf  out  1  wrap pulse, registered

## Operation
- Reset (clr=1, asynchronous): q=0, qb=all ones, ovf=0. Held while clr=1. Release is synchronous to the next posedge.
- Priority on each posedge: clr > load > en > hold.
- Load: q←d, qb←~d, ovf←0. Direction and en are ignored.
- Count (en=1, load=0): per-bit toggle vector t drives the stages.
  - Up: t[0]=1, t[i]=&q[i-1:0].
  - Down: t[0]=1, t[i]=&qb[i-1:0].
  - Each stage: q[i]←q[i]^t[i], qb[i]←~(q[i]^t[i]).
- Hold (en=0, load=0): q, qb unchanged, ovf←0.
- Wrap, binary mode: up from all-ones to 0; down from 0 to all-ones. Arithmetic is modulo 2^WIDTH, with no saturation.
- tc: up=1 → q==max; up=0 → q==0. Here max is 2^WIDTH−1, or MODULUS−1 when TCNT_MODULO_EN is defined. tc is independent of en.
- ovf←1 on any counting edge where tc=1 and en=1, i.e. the edge that wraps. Otherwise ovf←0, so it is a one-cycle pulse coincident with the wrapped q.
- The invariant qb==~q holds in every cycle, including during and after reset.

## Timing
- Latency: one clk from load/en/up sampled to q/qb update. ovf appears on the same edge as the wrapped value.
- Direction change takes effect on the same edge it is sampled. There is no dead cycle.
- tc follows q and up combinationally within the cycle.
- clr asserted mid-count forces q=0 immediately (asynchronously) and kills any pending ovf.
- load and en asserted together: load wins, and no ovf is generated.

## Configuration
- TCNT_MODULO_EN defined:
  - Counter wraps at MODULUS. Up from MODULUS−1 goes to 0; down from 0 goes to MODULUS−1.
  - The toggle vector is overridden on the wrap edge to force the target value.
  - A load of d ≥ MODULUS loads MODULUS−1.
  - tc and ovf use MODULUS−1 as max.
- TCNT_MODULO_EN undefined:
  - Pure binary 2^WIDTH counter.
  - MODULUS is ignored and no compare logic is generated.

## Structure
- Shared package tcnt_pkg:
  - Direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - Default WIDTH/MODULUS localparams.
- Sub-module t_stage: one toggle bit with inputs clk, clr (async), ld, ld_val and t, and outputs q and qb. The top generates WIDTH instances plus the toggle-vector and tc/ovf logic.

## Test plan
All scenarios use WIDTH=4.
1. Reset: assert clr mid-count at q=5 → q=0 and qb=4'b1111 immediately, before the next edge; ovf=0; tc=1 if up=0.
2. Up count: clr=0, en=1, up=1 for 16 edges from 0 → q steps 0..15 then 0. tc=1 only at q=15. Single ovf pulse with q=0. qb==~q every cycle.
3. Down count plus direction change: load d=2, then up=0 for 3 edges → 1, 0, 15 with ovf on the 15. Set up=1 → next edge gives 0.
4. Priority: load=1, d=9, en=1, at q=15 up → q=9 and ovf=0. Then en=0 for 3 edges → q holds at 9.
5. Modulo (TCNT_MODULO_EN, MODULUS=10), up from 8 → 9 (tc=1), then 0 with ovf=1. Down from 0 → 9. Load d=12 → q=9.
6. clr asserted on the same edge as load=1 → q=0; load is ignored.

Source files
------------

// File: rtl/tcnt_pkg.sv
// Shared constants for the toggle-counter family: direction encoding and
// default geometry.
package tcnt_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned TCNT_WIDTH_DEF   = 4;
  localparam int unsigned TCNT_MODULUS_DEF = 10;

endpackage : tcnt_pkg

// File: rtl/t_stage.sv
// Single toggle bit with complementary registered outputs.
// Ports:
//   clk    - clock, state updates on posedge
//   clr    - asynchronous active-high clear (q=0, qb=1)
//   ld     - synchronous load of ld_val (wins over t)
//   ld_val - load value
//   t      - toggle enable
//   q/qb   - registered bit and its complement
module t_stage
  import tcnt_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic ld,
  input  logic ld_val,
  input  logic t,
  output logic q,
  output logic qb
);

  logic q_q;
  logic q_d;
  logic qb_q;
  logic qb_d;

  // Next bit: load, otherwise toggle when t is set.
  always_comb begin
    q_d = q_q ^ t;
    if (ld) begin
      q_d = ld_val;
    end
    qb_d = ~q_d;
  end

  // qb is its own flop so both outputs come straight from registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q  <= 1'b0;
      qb_q <= 1'b1;
    end else begin
      q_q  <= q_d;
      qb_q <= qb_d;
    end
  end

  assign q  = q_q;
  assign qb = qb_q;

endmodule : t_stage

// File: rtl/t_toggle_counter.sv
// WIDTH-bit up/down counter built from a bank of t_stage toggle bits.
// Optional feature macro: TCNT_MODULO_EN (wrap at MODULUS instead of 2^WIDTH).
// Ports:
//   clk  - clock
//   clr  - asynchronous active-high clear
//   load - synchronous parallel load of d (priority over en)
//   d    - load value
//   en   - count enable
//   up   - direction, 1 = up, 0 = down
//   q/qb - registered count and its complement
//   tc   - terminal count, combinational from q and up
//   ovf  - registered one-cycle wrap pulse
module t_toggle_counter
  import tcnt_pkg::*;
#(
  parameter int unsigned WIDTH   = TCNT_WIDTH_DEF,
  parameter int unsigned MODULUS = TCNT_MODULUS_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             ovf
);

`ifdef TCNT_MODULO_EN
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
`else
  localparam logic [WIDTH-1:0] MAX_Q = {WIDTH{1'b1}};
`endif

  if (WIDTH < 2 || 64'(MODULUS) < 64'd2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_param_check
    $error("t_toggle_counter: illegal WIDTH/MODULUS");
  end

  logic [WIDTH-1:0] t_c;
  logic [WIDTH-1:0] sel_c;
  logic [WIDTH-1:0] ld_val_c;
  logic             run_c;
  logic             ovf_q;
  logic             ovf_d;

  assign tc = (up == DIR_UP) ? (q == MAX_Q) : (q == '0);

  // Toggle vector: bit i toggles when all lower bits of q (up) or qb (down) are set.
  always_comb begin
    t_c      = '0;
    ld_val_c = d;
    run_c    = 1'b1;
    sel_c    = (up == DIR_UP) ? q : qb;
    if (en) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        t_c[i] = run_c;
        run_c  = run_c & sel_c[i];
      end
    end
`ifdef TCNT_MODULO_EN
    // On the wrap edge steer every bit to the wrap target directly.
    if (en && tc) begin
      t_c = q ^ ((up == DIR_UP) ? '0 : MAX_Q);
    end
    if (32'(d) >= MODULUS) begin
      ld_val_c = MAX_Q;
    end
`endif
    ovf_d = en && tc && !load;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
    t_stage u_stage (
      .clk    (clk),
      .clr    (clr),
      .ld     (load),
      .ld_val (ld_val_c[i]),
      .t      (t_c[i]),
      .q      (q[i]),
      .qb     (qb[i])
    );
  end

endmodule : t_toggle_counter

// File: tb/tb_t_toggle_counter.sv
// Self-checking bench for t_toggle_counter (WIDTH=4) against an arithmetic
// reference model of the count value.
module tb_t_toggle_counter;
  import tcnt_pkg::*;

  localparam int unsigned W     = 4;
  localparam int unsigned MOD_P = 10;
`ifdef TCNT_MODULO_EN
  localparam int MODV = int'(MOD_P);
`else
  localparam int MODV = 16;
`endif

  logic         clk = 1'b0;
  logic         clr;
  logic         load;
  logic         en;
  logic         up;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         tc;
  logic         ovf;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_q;
  logic m_ovf;

  always #5 clk = ~clk;

  t_toggle_counter #(.WIDTH(W), .MODULUS(MOD_P)) dut (
    .clk  (clk),
    .clr  (clr),
    .load (load),
    .d    (d),
    .en   (en),
    .up   (up),
    .q    (q),
    .qb   (qb),
    .tc   (tc),
    .ovf  (ovf)
  );

  function automatic logic exp_tc();
    return (up == DIR_UP) ? (m_q == MODV - 1) : (m_q == 0);
  endfunction

  // Reference: count modulo MODV, ovf set on the edge that leaves a terminal value.
  function automatic void model_step();
    if (clr) begin
      m_q = 0; m_ovf = 1'b0;
    end else if (load) begin
      m_q = (int'(d) >= MODV) ? MODV - 1 : int'(d);
      m_ovf = 1'b0;
    end else if (en) begin
      m_ovf = exp_tc();
      m_q = up ? (m_q + 1) % MODV : (m_q + MODV - 1) % MODV;
    end else begin
      m_ovf = 1'b0;
    end
  endfunction

  function automatic logic [2*W+1:0] exp_vec();
    return {W'(m_q), ~W'(m_q), m_ovf, exp_tc()};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; d = '0;
    m_q = 0; m_ovf = 1'b0;
    tick(); tick();
    n_tests++;
    if ({q, qb, ovf, tc} !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_hold: got q=%0d qb=%b ovf=%b tc=%b exp vec=%b", q, qb, ovf, tc, exp_vec());
    end
    clr = 1'b0; en = 1'b1;
    repeat (5) tick();
    n_tests++;
    if (q !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_precount: got q=%0d exp 5", q);
    end
    // Asynchronous clear mid-cycle, checked before any edge.
    up = 1'b0; clr = 1'b1;
    m_q = 0; m_ovf = 1'b0;
    #1;
    n_tests++;
    if ({q, qb, ovf, tc} !== {4'd0, 4'b1111, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_async: got q=%0d qb=%b ovf=%b tc=%b exp q=0 qb=1111 ovf=0 tc=1", q, qb, ovf, tc);
    end
    tick();
    clr = 1'b0; en = 1'b0; up = 1'b1;
    #1;
  endtask

  task automatic test_up_count();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      n_tests++;
      if ({q, qb, ovf, tc} !== exp_vec()) begin
        n_fail++;
        $display("FAIL up_count step %0d: got q=%0d qb=%b ovf=%b tc=%b exp vec=%b", i, q, qb, ovf, tc, exp_vec());
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_down_dir();
    load = 1'b1; d = 4'd2; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({q, qb, ovf, tc} !== exp_vec()) begin
        n_fail++;
        $display("FAIL down_count step %0d: got q=%0d qb=%b ovf=%b tc=%b exp vec=%b", i, q, qb, ovf, tc, exp_vec());
      end
    end
    // Direction flip: tc follows immediately, next edge counts up.
    up = 1'b1;
    #1;
    n_tests++;
    if (tc !== exp_tc()) begin
      n_fail++;
      $display("FAIL dir_tc: got tc=%b exp %b", tc, exp_tc());
    end
    tick();
    n_tests++;
    if ({q, qb, ovf, tc} !== exp_vec()) begin
      n_fail++;
      $display("FAIL dir_change: got q=%0d qb=%b ovf=%b tc=%b exp vec=%b", q, qb, ovf, tc, exp_vec());
    end
  endtask

  task automatic test_priority();
    load = 1'b1; d = 4'(MODV - 1); en = 1'b0;
    tick();
    load = 1'b1; d = 4'd9; en = 1'b1; up = 1'b1;
    tick();
    n_tests++;
    if ({q, qb, ovf, tc} !== exp_vec() || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL load_over_en: got q=%0d qb=%b ovf=%b tc=%b exp vec=%b", q, qb, ovf, tc, exp_vec());
    end
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({q, qb, ovf, tc} !== exp_vec()) begin
        n_fail++;
        $display("FAIL hold step %0d: got q=%0d qb=%b ovf=%b tc=%b exp vec=%b", i, q, qb, ovf, tc, exp_vec());
      end
    end
  endtask

`ifdef TCNT_MODULO_EN
  task automatic test_modulo();
    load = 1'b1; d = 4'd8; en = 1'b0; up = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) up = 1'b0;
      tick();
      n_tests++;
      if ({q, qb, ovf, tc} !== exp_vec()) begin
        n_fail++;
        $display("FAIL modulo step %0d: got q=%0d qb=%b ovf=%b tc=%b exp vec=%b", i, q, qb, ovf, tc, exp_vec());
      end
    end
    load = 1'b1; d = 4'd12;
    tick();
    n_tests++;
    if (q !== 4'd9) begin
      n_fail++;
      $display("FAIL modulo_load_clamp: got q=%0d exp 9", q);
    end
    load = 1'b0;
  endtask
`endif

  task automatic test_clr_load();
    load = 1'b1; d = 4'd7; en = 1'b1; clr = 1'b1;
    tick();
    n_tests++;
    if ({q, qb, ovf, tc} !== exp_vec() || q !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_over_load: got q=%0d qb=%b ovf=%b tc=%b exp vec=%b", q, qb, ovf, tc, exp_vec());
    end
    clr = 1'b0; load = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 31) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom);
      d    = W'($urandom);
      tick();
      n_tests++;
      if ({q, qb, ovf, tc} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got q=%0d qb=%b ovf=%b tc=%b exp vec=%b", i, q, qb, ovf, tc, exp_vec());
      end
    end
    clr = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_dir();
    test_priority();
`ifdef TCNT_MODULO_EN
    test_modulo();
`endif
    test_clr_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_t_toggle_counter
